// File: rtl/wave_capture.sv
// wave_capture: serial-to-parallel capture of a 1-bit wave into a buffer of
// DEPTH words of WORD_W bits, LSB first, with a combinational readback port.
module wave_capture #(
   parameter int WORD_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              start,
   input  logic              wave,
   output logic              busy,
   output logic              done,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_out,
   output logic [ADDR_W-1:0] word_idx,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   // Holds the first WORD_W-1 bits of the word; the last bit comes straight
   // from the wave input on the completing edge.
   logic [WORD_W-2:0]   shreg_q, shreg_d;
   logic [WORD_W-1:0]   word_out_q, word_out_d;
   logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
   logic                word_valid_q, word_valid_d;

   logic [WORD_W-1:0]   mem [DEPTH];
   logic                wr_en;
   logic [WORD_W-1:0]   wr_word;

   // Next-state and datapath update for the capture FSM
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      word_out_d   = word_out_q;
      word_idx_d   = word_idx_q;
      word_valid_d = 1'b0;
      wr_en        = 1'b0;
      wr_word      = {wave, shreg_q};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_CAPTURE;
               bit_cnt_d  = '0;
               word_idx_d = '0;
            end
         end
         S_CAPTURE: begin
            shreg_d   = {wave, shreg_q[WORD_W-2:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
               wr_en        = 1'b1;
               word_out_d   = wr_word;
               word_valid_d = 1'b1;
               bit_cnt_d    = '0;
               if (word_idx_q == ADDR_W'(DEPTH - 1)) begin
                  word_idx_d = '0;
                  state_d    = S_DONE;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               state_d    = S_CAPTURE;
               bit_cnt_d  = '0;
               word_idx_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and control registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         word_out_q   <= '0;
         word_idx_q   <= '0;
         word_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         word_out_q   <= word_out_d;
         word_idx_q   <= word_idx_d;
         word_valid_q <= word_valid_d;
      end
   end

   // Capture buffer: not cleared by reset, and a clear suppresses any write
   always_ff @(posedge clk) begin
      if (clear_n && wr_en) begin
         mem[word_idx_q] <= wr_word;
      end
   end

   // Outputs
   always_comb begin
      busy       = (state_q == S_CAPTURE);
      done       = (state_q == S_DONE);
      word_valid = word_valid_q;
      word_out   = word_out_q;
      word_idx   = word_idx_q;
      rd_data    = mem[rd_addr];
   end

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: randomized and directed checks of wave_capture against a
// word-level model of the capture buffer.
module tb_wave_capture;

   localparam int WORD_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              clear_n = 1'b0;
   logic              start = 1'b0;
   logic              wave = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              busy, done, word_valid;
   logic [WORD_W-1:0] word_out, rd_data;
   logic [ADDR_W-1:0] word_idx;

   int errors = 0;
   int checks = 0;

   // Model: words being sent, and what the buffer should hold
   logic [7:0] stim_words [16];
   logic [7:0] exp_mem    [16];
   bit         exp_known  [16];

   // Observations per edge relative to the start edge T
   logic       obs_valid [129];
   logic       obs_busy  [129];
   logic       obs_done  [129];
   logic [7:0] obs_out   [129];
   logic [3:0] obs_idx   [129];
   logic [7:0] obs_rd    [129];

   wave_capture #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .clear_n(clear_n), .start(start), .wave(wave),
      .busy(busy), .done(done), .word_valid(word_valid),
      .word_out(word_out), .word_idx(word_idx),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the serial stream of stim_words for edges T+1..T+n, recording outputs
   task automatic clock_bits(input int n, input int restart_edge);
      for (int e = 1; e <= n; e++) begin
         wave  = stim_words[((e - 1) / 8) % 16][(e - 1) % 8];
         start = (e == restart_edge);
         rd_addr = 4'(((e + 7) / 8 - 1) % 16);
         #1;
         obs_rd[e] = rd_data;
         tick();
         obs_valid[e] = word_valid;
         obs_busy[e]  = busy;
         obs_done[e]  = done;
         obs_out[e]   = word_out;
         obs_idx[e]   = word_idx;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      clear_n = 1'b0; wave = 1'b1; start = 1'b0;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
      checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word_out: got %h expected 00", word_out); end
      checks++; if (word_idx !== 4'd0) begin errors++; $display("FAIL reset_word_idx: got %0d expected 0", word_idx); end
      start = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_beats_start: busy got %b expected 0", busy); end
      start = 1'b0; clear_n = 1'b1; wave = 1'b0;
      tick();
   endtask

   task automatic test_full_run();
      for (int i = 0; i < 16; i++) stim_words[i] = (i % 2 == 0) ? 8'hCC : 8'hAA;
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_after_start: got %b expected 1", busy); end
      clock_bits(128, 0);
      for (int e = 1; e <= 128; e++) begin
         checks++;
         if (obs_valid[e] !== (e % 8 == 0)) begin errors++; $display("FAIL full_valid e=%0d: got %b expected %b", e, obs_valid[e], (e % 8 == 0)); end
         if (e % 8 == 0) begin
            checks++;
            if (obs_out[e] !== stim_words[e / 8 - 1]) begin errors++; $display("FAIL full_word_out e=%0d: got %h expected %h", e, obs_out[e], stim_words[e / 8 - 1]); end
            checks++;
            if (obs_idx[e] !== 4'((e / 8) % 16)) begin errors++; $display("FAIL full_word_idx e=%0d: got %0d expected %0d", e, obs_idx[e], (e / 8) % 16); end
            exp_mem[e / 8 - 1] = stim_words[e / 8 - 1];
            exp_known[e / 8 - 1] = 1'b1;
         end
      end
      checks++; if (obs_busy[127] !== 1'b1 || obs_done[127] !== 1'b0) begin errors++; $display("FAIL full_busy_127: got busy=%b done=%b expected 1 0", obs_busy[127], obs_done[127]); end
      checks++; if (obs_busy[128] !== 1'b0 || obs_done[128] !== 1'b1) begin errors++; $display("FAIL full_done_128: got busy=%b done=%b expected 0 1", obs_busy[128], obs_done[128]); end
      wave = 1'b1;
      tick();
      checks++; if (word_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL full_after_done: got valid=%b done=%b expected 0 1", word_valid, done); end
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); #1;
         checks++;
         if (rd_data !== ((a % 2 == 0) ? 8'hCC : 8'hAA)) begin errors++; $display("FAIL full_readback a=%0d: got %h expected %h", a, rd_data, (a % 2 == 0) ? 8'hCC : 8'hAA); end
      end
   endtask

   task automatic test_start_ignored();
      int pulses;
      for (int i = 0; i < 16; i++) stim_words[i] = 8'($urandom);
      start = 1'b1; tick(); start = 1'b0;
      clock_bits(128, 4);
      checks++; if (obs_valid[8] !== 1'b1 || obs_out[8] !== stim_words[0]) begin errors++; $display("FAIL ign_word0: got valid=%b %h expected 1 %h", obs_valid[8], obs_out[8], stim_words[0]); end
      checks++; if (obs_busy[127] !== 1'b1 || obs_done[127] !== 1'b0) begin errors++; $display("FAIL ign_busy_127: got busy=%b done=%b expected 1 0", obs_busy[127], obs_done[127]); end
      checks++; if (obs_done[128] !== 1'b1) begin errors++; $display("FAIL ign_done_128: got %b expected 1", obs_done[128]); end
      pulses = 0;
      for (int e = 1; e <= 128; e++) if (obs_valid[e] === 1'b1) pulses++;
      checks++; if (pulses != 16) begin errors++; $display("FAIL ign_pulse_count: got %0d expected 16", pulses); end
      for (int w = 0; w < 16; w++) begin
         if (exp_known[w]) begin
            checks++;
            if (obs_rd[8 * (w + 1)] !== exp_mem[w]) begin errors++; $display("FAIL ign_read_old w=%0d: got %h expected %h", w, obs_rd[8 * (w + 1)], exp_mem[w]); end
         end
         checks++;
         if (obs_out[8 * (w + 1)] !== stim_words[w]) begin errors++; $display("FAIL ign_word w=%0d: got %h expected %h", w, obs_out[8 * (w + 1)], stim_words[w]); end
         exp_mem[w] = stim_words[w];
         exp_known[w] = 1'b1;
      end
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); #1;
         checks++;
         if (rd_data !== exp_mem[a]) begin errors++; $display("FAIL ign_readback a=%0d: got %h expected %h", a, rd_data, exp_mem[a]); end
      end
   endtask

   task automatic test_done_restart();
      int pulses;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_in_done: got %b expected 1", done); end
      for (int i = 0; i < 16; i++) stim_words[i] = 8'hFF;
      wave = 1'b1; start = 1'b1; tick(); start = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_after_start: got done=%b busy=%b expected 0 1", done, busy); end
      clock_bits(128, 0);
      pulses = 0;
      for (int e = 8; e <= 128; e += 8) if (obs_valid[e] === 1'b1 && obs_out[e] === 8'hFF) pulses++;
      checks++; if (pulses != 16) begin errors++; $display("FAIL rst_ff_words: got %0d expected 16", pulses); end
      checks++; if (obs_done[127] !== 1'b0 || obs_done[128] !== 1'b1) begin errors++; $display("FAIL rst_done_again: got %b%b expected 01", obs_done[127], obs_done[128]); end
      for (int a = 0; a < 16; a++) begin
         exp_mem[a] = 8'hFF;
         rd_addr = 4'(a); #1;
         checks++;
         if (rd_data !== 8'hFF) begin errors++; $display("FAIL rst_readback a=%0d: got %h expected ff", a, rd_data); end
      end
   endtask

   task automatic test_idle_ignore();
      int pulses;
      clear_n = 1'b0; tick(); clear_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         wave = ~wave;
         tick();
         if (word_valid !== 1'b0) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
      checks++; if (word_out !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL idle_word_out: got %h busy=%b expected 00 0", word_out, busy); end
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); #1;
         checks++;
         if (rd_data !== exp_mem[a]) begin errors++; $display("FAIL idle_readback a=%0d: got %h expected %h", a, rd_data, exp_mem[a]); end
      end
   endtask

   task automatic test_clear_mid();
      logic [7:0] nw;
      for (int i = 0; i < 16; i++) stim_words[i] = 8'($urandom);
      start = 1'b1; tick(); start = 1'b0;
      clock_bits(42, 0);
      for (int w = 0; w < 5; w++) begin
         checks++;
         if (obs_out[8 * (w + 1)] !== stim_words[w]) begin errors++; $display("FAIL clr_word w=%0d: got %h expected %h", w, obs_out[8 * (w + 1)], stim_words[w]); end
         exp_mem[w] = stim_words[w];
      end
      wave = 1'($urandom); clear_n = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0 || word_valid !== 1'b0) begin errors++; $display("FAIL clr_flags: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, word_valid); end
      checks++; if (word_out !== 8'h00 || word_idx !== 4'd0) begin errors++; $display("FAIL clr_regs: got %h %0d expected 00 0", word_out, word_idx); end
      clear_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); #1;
         checks++;
         if (rd_data !== exp_mem[a]) begin errors++; $display("FAIL clr_readback a=%0d: got %h expected %h", a, rd_data, exp_mem[a]); end
      end
      nw = 8'($urandom);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wave = nw[k];
         tick();
         checks++;
         if (word_valid !== (k == 7)) begin errors++; $display("FAIL clr_new_valid k=%0d: got %b expected %b", k, word_valid, (k == 7)); end
      end
      checks++; if (word_out !== nw || word_idx !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL clr_new_word: got %h idx=%0d busy=%b expected %h 1 1", word_out, word_idx, busy, nw); end
      exp_mem[0] = nw;
      rd_addr = 4'd0; #1;
      checks++; if (rd_data !== exp_mem[0]) begin errors++; $display("FAIL clr_new_readback: got %h expected %h", rd_data, exp_mem[0]); end
      clear_n = 1'b0; tick(); clear_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         exp_mem[i] = 8'h00;
         exp_known[i] = 1'b0;
      end
      test_reset();
      test_full_run();
      test_start_ignored();
      test_done_restart();
      test_idle_ignore();
      test_clear_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
